// File: rtl/pe_array_out_collector.sv
// Drains rightmost-PE accumulation results, rescales each row to output-buffer
// width with saturation, and writes one packed beat per chain read.
module pe_array_out_collector #(
    parameter int num_pe_row   = 1,
    parameter int output_width = 24,
    parameter int ob_width     = 16,
    parameter int fifo_depth   = 4,
    parameter int read_latency = 1,
    parameter int cnt_width    = 12,
    parameter int addr_width   = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [cnt_width-1:0]               cfg_num_words,
    input  logic [4:0]                         cfg_shift,
    input  logic [addr_width-1:0]              cfg_base_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               drain_read,
    input  logic                               chain_empty,
    input  logic [num_pe_row*output_width-1:0] chain_data,
    output logic                               ob_valid,
    input  logic                               ob_ready,
    output logic [num_pe_row*ob_width-1:0]     ob_data,
    output logic [addr_width-1:0]              ob_addr,
    output logic                               ob_last
);
    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int BW = num_pe_row * ob_width;
    localparam logic signed [output_width-1:0] SAT_MAX =
        {{(output_width-ob_width+1){1'b0}}, {(ob_width-1){1'b1}}};
    localparam logic signed [output_width-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, FIN} state_t;

    function automatic logic [ob_width-1:0] rescale(input logic signed [output_width-1:0] w,
                                                    input logic [4:0] sh);
        logic signed [output_width-1:0] s;
        s = w >>> sh;
        if (s > SAT_MAX)      return SAT_MAX[ob_width-1:0];
        else if (s < SAT_MIN) return SAT_MIN[ob_width-1:0];
        else                  return s[ob_width-1:0];
    endfunction

    state_t                  state_q;
    logic [cnt_width-1:0]    num_words_q, issued_q, beat_q;
    logic [4:0]              shift_q;
    logic [addr_width-1:0]   base_q;
    logic [read_latency-1:0] rd_vld_q;
    logic [BW-1:0]           fifo_mem [fifo_depth];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [PW:0]             fifo_cnt_q;
    logic                    ob_valid_q, ob_last_q;
    logic [BW-1:0]           ob_data_q;
    logic [addr_width-1:0]   ob_addr_q;

    logic [BW-1:0] cap_word, load_data;
    logic          rd_issue, cap, fifo_empty, ob_free, load, push, pop;
    int            inflight, occ;

    for (genvar r = 0; r < num_pe_row; r++) begin : g_row
        assign cap_word[r*ob_width +: ob_width] =
            rescale($signed(chain_data[r*output_width +: output_width]), shift_q);
    end

    // Credit: FIFO entries, the output register and reads still in flight all hold a slot.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < read_latency; i++) inflight += int'(rd_vld_q[i]);
        occ = int'(fifo_cnt_q) + int'(ob_valid_q) + inflight;
    end

    assign rd_issue   = (state_q == DRAIN) && (issued_q < num_words_q) && !chain_empty
                        && (occ < fifo_depth);
    assign cap        = rd_vld_q[read_latency-1];
    assign fifo_empty = (fifo_cnt_q == '0);
    assign ob_free    = !ob_valid_q || ob_ready;
    assign load       = ob_free && (!fifo_empty || cap);
    assign pop        = ob_free && !fifo_empty;
    assign push       = cap && !(fifo_empty && ob_free);
    assign load_data  = fifo_empty ? cap_word : fifo_mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            num_words_q <= '0;
            shift_q     <= '0;
            base_q      <= '0;
            issued_q    <= '0;
            rd_vld_q    <= '0;
        end else begin
            rd_vld_q[0] <= rd_issue;
            for (int i = 1; i < read_latency; i++) rd_vld_q[i] <= rd_vld_q[i-1];
            if (rd_issue) issued_q <= issued_q + cnt_width'(1);
            case (state_q)
                IDLE: if (start) begin
                    num_words_q <= cfg_num_words;
                    shift_q     <= cfg_shift;
                    base_q      <= cfg_base_addr;
                    issued_q    <= '0;
                    state_q     <= (cfg_num_words == '0) ? FIN : DRAIN;
                end
                DRAIN: if (issued_q == num_words_q) state_q <= FLUSH;
                // The beat handshaking now is the last one once nothing else is pending.
                FLUSH: if (inflight == 0 && fifo_empty && ob_free) state_q <= FIN;
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            beat_q     <= '0;
            ob_valid_q <= 1'b0;
            ob_data_q  <= '0;
            ob_addr_q  <= '0;
            ob_last_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (PW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (PW+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (state_q == IDLE && start) beat_q <= '0;
            else if (load)                beat_q <= beat_q + cnt_width'(1);
            if (load) begin
                ob_valid_q <= 1'b1;
                ob_data_q  <= load_data;
                ob_addr_q  <= base_q + addr_width'(beat_q);
                ob_last_q  <= (beat_q == num_words_q - cnt_width'(1));
            end else if (ob_ready) begin
                ob_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cap_word;
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign drain_read = rd_issue;
    assign ob_valid   = ob_valid_q;
    assign ob_data    = ob_data_q;
    assign ob_addr    = ob_addr_q;
    assign ob_last    = ob_last_q;
endmodule

// File: tb/tb_pe_array_out_collector.sv
// Directed bench for pe_array_out_collector with a two-row chain model and
// an expected-beat queue checked at every output handshake.
module tb_pe_array_out_collector;
    logic        clk = 0, rst = 0, start = 0;
    logic [11:0] cfg_num_words = 0;
    logic [4:0]  cfg_shift = 0;
    logic [11:0] cfg_base_addr = 0;
    logic        busy, done, drain_read, ob_valid, ob_last;
    logic        chain_empty = 1, ob_ready = 0;
    logic [47:0] chain_data = 0;
    logic [31:0] ob_data;
    logic [11:0] ob_addr;

    int checks = 0, errors = 0;
    int cyc = 0, nreads = 0, beats = 0, last_hs = 0, n0 = 0, b0 = 0;
    logic stall = 0, rd_pend = 0;
    logic [47:0] chq[$];
    logic [31:0] exp_d[$];
    logic [11:0] exp_a[$];
    logic        exp_l[$];

    pe_array_out_collector #(.num_pe_row(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_words(cfg_num_words),
        .cfg_shift(cfg_shift), .cfg_base_addr(cfg_base_addr), .busy(busy), .done(done),
        .drain_read(drain_read), .chain_empty(chain_empty), .chain_data(chain_data),
        .ob_valid(ob_valid), .ob_ready(ob_ready), .ob_data(ob_data), .ob_addr(ob_addr),
        .ob_last(ob_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic upd_empty();
        chain_empty = stall || (chq.size() == 0);
    endtask

    task automatic push_word(input logic [23:0] r1, input logic [23:0] r0);
        chq.push_back({r1, r0});
        upd_empty();
    endtask

    task automatic push_beat(input logic [15:0] r1, input logic [15:0] r0,
                             input logic [11:0] a, input logic l);
        exp_d.push_back({r1, r0});
        exp_a.push_back(a);
        exp_l.push_back(l);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [11:0] nw, input logic [4:0] sh, input logic [11:0] base);
        cfg_num_words = nw;
        cfg_shift     = sh;
        cfg_base_addr = base;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        while (!done && k < max) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_done_lat"}, 64'(cyc - last_hs), 64'd1);
        check({tag, "_beats_left"}, 64'(exp_d.size()), 64'd0);
        tick(1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Chain model: a read seen before an edge presents its word just after that edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (drain_read) begin
                nreads++;
                rd_pend = 1;
            end
            if (ob_valid && ob_ready) begin
                if (exp_d.size() == 0) begin
                    check("extra_beat", 64'(exp_d.size()), 64'd1);
                end else begin
                    check("beat_data", 64'(ob_data), 64'(exp_d.pop_front()));
                    check("beat_addr", 64'(ob_addr), 64'(exp_a.pop_front()));
                    check("beat_last", 64'(ob_last), 64'(exp_l.pop_front()));
                end
                beats++;
                last_hs = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            rd_pend = 0;
            if (chq.size() > 0) chain_data = chq.pop_front();
            upd_empty();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1;
        tick(2);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_drain_read", 64'(drain_read), 0);
        check("rst_ob_valid", 64'(ob_valid), 0);
        check("rst_ob_data", 64'(ob_data), 0);
        check("rst_ob_addr", 64'(ob_addr), 0);
        check("rst_ob_last", 64'(ob_last), 0);
        rst = 0;
        tick(1);

        // Pass-through, shift 0; row 1 also exercises saturation at shift 0.
        ob_ready = 1;
        push_word(24'h000001, 24'h000005);
        push_word(24'h7FFFFF, 24'hFFFFF9);
        push_word(24'hFFFFFF, 24'h000064);
        push_beat(16'h0001, 16'h0005, 12'h010, 0);
        push_beat(16'h7FFF, 16'hFFF9, 12'h011, 0);
        push_beat(16'hFFFF, 16'h0064, 12'h012, 1);
        n0 = nreads;
        start_job(3, 0, 12'h010);
        wait_done("pass", 100);
        check("pass_reads", 64'(nreads - n0), 3);

        // Saturation and floor shift by 4.
        push_word(24'h000010, 24'h7FFFFF);
        push_word(24'hFFFFF0, 24'h800000);
        push_word(24'hFFFFFF, 24'h012340);
        push_beat(16'h0001, 16'h7FFF, 12'h100, 0);
        push_beat(16'hFFFF, 16'h8000, 12'h101, 0);
        push_beat(16'hFFFF, 16'h1234, 12'h102, 1);
        start_job(3, 4, 12'h100);
        wait_done("sat", 100);

        // Backpressure: credit stops reads at fifo_depth outstanding words.
        ob_ready = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(24'(-(2 * i)), 24'(i * 'h100));
            push_beat(16'(-i), 16'(i * 'h80), 12'(12'h200 + i), i == 9);
        end
        n0 = nreads;
        start_job(10, 1, 12'h200);
        tick(20);
        check("bp_reads_held", 64'(nreads - n0), 4);
        check("bp_valid", 64'(ob_valid), 1);
        check("bp_hold_addr", 64'(ob_addr), 64'h200);
        ob_ready = 1;
        wait_done("bp", 200);
        check("bp_reads_total", 64'(nreads - n0), 10);

        // Chain stall mid-job.
        for (int i = 0; i < 6; i++) begin
            push_word(24'h0, 24'(10 + i));
            push_beat(16'h0, 16'(10 + i), 12'(12'h300 + i), i == 5);
        end
        n0 = nreads;
        start_job(6, 0, 12'h300);
        tick(2);
        stall = 1;
        upd_empty();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_read", 64'(drain_read), 0);
        end
        tick(1);
        stall = 0;
        upd_empty();
        wait_done("stall", 100);
        check("stall_reads", 64'(nreads - n0), 6);

        // Zero-length job: no reads even with data waiting.
        push_word(24'h0, 24'h55);
        n0 = nreads;
        b0 = beats;
        start_job(0, 0, 12'h0);
        @(negedge clk);
        check("zero_done", 64'(done), 1);
        tick(3);
        check("zero_reads", 64'(nreads - n0), 0);
        check("zero_beats", 64'(beats - b0), 0);
        check("zero_idle", 64'(busy), 0);
        chq.delete();
        upd_empty();

        // Address wrap, with a second start while busy that must be ignored.
        ob_ready = 0;
        push_word(24'h0, 24'h11);
        push_word(24'h0, 24'h22);
        push_beat(16'h0, 16'h11, 12'hFFF, 0);
        push_beat(16'h0, 16'h22, 12'h000, 1);
        n0 = nreads;
        start_job(2, 0, 12'hFFF);
        tick(3);
        start_job(5, 3, 12'h777);
        tick(2);
        ob_ready = 1;
        wait_done("wrap", 100);
        check("wrap_reads", 64'(nreads - n0), 2);

        // Reset mid-job with a beat held.
        ob_ready = 0;
        for (int i = 0; i < 8; i++) push_word(24'h0, 24'(i + 1));
        start_job(8, 0, 12'h050);
        tick(4);
        check("rst_mid_pre_valid", 64'(ob_valid), 1);
        rst = 1;
        n0 = nreads;
        #1;
        check("rst_mid_valid", 64'(ob_valid), 0);
        check("rst_mid_data", 64'(ob_data), 0);
        check("rst_mid_addr", 64'(ob_addr), 0);
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_drain", 64'(drain_read), 0);
        tick(2);
        rst = 0;
        ob_ready = 1;
        tick(5);
        check("rst_mid_no_read", 64'(nreads - n0), 0);
        check("rst_mid_no_valid", 64'(ob_valid), 0);
        check("rst_mid_idle", 64'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
